// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Brief    : Shared data-bus widths, store-buffer entry layout and bus FSM
//            state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int DBUS_AW = 32;
    localparam int DBUS_DW = 32;

    // One buffered store: byte address, lane-aligned data and byte enables.
    typedef struct packed {
        logic [DBUS_AW-1:0]   addr;
        logic [DBUS_DW-1:0]   data;
        logic [DBUS_DW/8-1:0] strb;
    } sb_entry_t;

    // Bus side state: idle, or holding a request on the bus.
    typedef enum logic [0:0] {
        SB_IDLE = 1'b0,
        SB_REQ  = 1'b1
    } sb_state_e;

endpackage : core_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Generic DEPTH x WIDTH register FIFO. Exposes the head entry and
//            the entry behind it so a consumer can issue back-to-back.
//            A pop in the same cycle does not make room for that cycle's push.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head,
    output logic [WIDTH-1:0]         head_next
);

    localparam int                 c_pw    = $clog2(DEPTH);
    localparam logic [c_pw:0]      c_depth = (c_pw+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_pw-1:0]  r_wr_ptr;
    logic [c_pw-1:0]  r_rd_ptr;
    logic [c_pw:0]    r_count;

    logic             w_push;
    logic             w_pop;
    logic [c_pw-1:0]  w_rd_next;

    // Full/empty come from the registered count only, never from this cycle's pop.
    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_push    = push & ~full;
    assign w_pop     = pop & ~empty;
    assign w_rd_next = r_rd_ptr + 1'b1;
    assign head      = r_mem[r_rd_ptr];
    assign head_next = r_mem[w_rd_next];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap on power-of-2 depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/store_buf.sv
`default_nettype none
// ============================================================================
// Module   : store_buf
// Brief    : Store buffer between writeback and the data bus. Commits stores
//            into a FIFO and drains them in order with a req/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
module store_buf
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = DBUS_AW,
    parameter int DW    = DBUS_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_dbus_en,
    input  logic [AW-1:0]   st_addr,
    input  logic [DW-1:0]   st_data,
    input  logic [DW/8-1:0] st_strb,
    output logic            st_stall,
    output logic            sb_empty,
    output logic            dbus_req,
    output logic            dbus_we,
    output logic [AW-1:0]   dbus_addr,
    output logic [DW-1:0]   dbus_wdata,
    output logic [DW/8-1:0] dbus_wstrb,
    input  logic            dbus_ack,
    input  logic            dbus_err,
    output logic            st_err
);

    localparam int            c_pw    = $clog2(DEPTH);
    localparam int            c_ew    = $bits(sb_entry_t);
    localparam logic [c_pw:0] c_one   = (c_pw+1)'(1);

    sb_entry_t      w_in_entry;
    sb_entry_t      w_head;
    sb_entry_t      w_head_next;
    logic           w_full;
    logic           w_fifo_empty;
    logic [c_pw:0]  w_count;
    logic           w_pop;

    sb_state_e      r_state;
    logic           r_dbus_req;
    sb_entry_t      r_bus;
    logic           r_st_err;

    assign w_in_entry.addr = st_addr;
    assign w_in_entry.data = st_data;
    assign w_in_entry.strb = st_strb;

    // A handshake completes only while our request is on the bus.
    assign w_pop = r_dbus_req & dbus_ack;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ew)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_dbus_en),
        .pop       (w_pop),
        .din       (w_in_entry),
        .full      (w_full),
        .empty     (w_fifo_empty),
        .count     (w_count),
        .head      (w_head),
        .head_next (w_head_next)
    );

    assign st_stall   = w_full;
    assign sb_empty   = w_fifo_empty & (r_state == SB_IDLE);
    assign dbus_req   = r_dbus_req;
    assign dbus_we    = r_dbus_req;
    assign dbus_addr  = r_bus.addr;
    assign dbus_wdata = r_bus.data;
    assign dbus_wstrb = r_bus.strb;
    assign st_err     = r_st_err;

    // Bus FSM: issue the FIFO head, hold it until ack, chain back-to-back
    // while more entries are already queued at the time of the ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= SB_IDLE;
            r_dbus_req <= 1'b0;
            r_bus      <= '0;
            r_st_err   <= 1'b0;
        end else begin
            r_st_err <= dbus_ack & dbus_err & r_dbus_req;
            case (r_state)
                SB_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_bus      <= w_head;
                        r_dbus_req <= 1'b1;
                        r_state    <= SB_REQ;
                    end
                end
                SB_REQ: begin
                    if (dbus_ack) begin
                        // A push landing this cycle is not counted: it is
                        // issued later from IDLE rather than chained here.
                        if (w_count != c_one) begin
                            r_bus <= w_head_next;
                        end else begin
                            r_dbus_req <= 1'b0;
                            r_state    <= SB_IDLE;
                        end
                    end
                end
                default: begin
                    r_dbus_req <= 1'b0;
                    r_state    <= SB_IDLE;
                end
            endcase
        end
    end

endmodule : store_buf
`default_nettype wire

// File: tb/tb_store_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buf
// Brief    : Self-checking bench for store_buf. A queue-level model of the
//            buffer predicts bus outputs every cycle; directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_buf;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_dbus_en;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_strb;
    logic        st_stall;
    logic        sb_empty;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_wstrb;
    logic        dbus_ack;
    logic        dbus_err;
    logic        st_err;

    store_buf #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_dbus_en (wr_dbus_en),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_strb    (st_strb),
        .st_stall   (st_stall),
        .sb_empty   (sb_empty),
        .dbus_req   (dbus_req),
        .dbus_we    (dbus_we),
        .dbus_addr  (dbus_addr),
        .dbus_wdata (dbus_wdata),
        .dbus_wstrb (dbus_wstrb),
        .dbus_ack   (dbus_ack),
        .dbus_err   (dbus_err),
        .st_err     (st_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } st_t;

    // Model: queue of accepted stores; head is on the bus whenever m_req is set.
    st_t mq[$];
    bit  m_req;
    bit  m_err;
    int  n_checks;
    int  n_errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across one rising edge using the inputs present there.
    task automatic model_step();
        bit accept;
        bit hs;
        if (rst) begin
            mq.delete();
            m_req = 1'b0;
            m_err = 1'b0;
            return;
        end
        accept = wr_dbus_en && (mq.size() < DEPTH);
        hs     = m_req && dbus_ack;
        m_err  = hs && dbus_err;
        if (hs) void'(mq.pop_front());
        if (m_req) m_req = hs ? (mq.size() != 0) : 1'b1;
        else       m_req = (mq.size() != 0);
        if (accept) mq.push_back('{st_addr, st_data, st_strb});
    endtask

    task automatic compare();
        check("req",   dbus_req, m_req);
        check("we",    dbus_we,  m_req);
        check("stall", st_stall, mq.size() == DEPTH);
        check("empty", sb_empty, (mq.size() == 0) && !m_req);
        check("err",   st_err,   m_err);
        if (m_req && mq.size() > 0) begin
            check("addr",  dbus_addr,  mq[0].addr);
            check("wdata", dbus_wdata, mq[0].data);
            check("wstrb", dbus_wstrb, mq[0].strb);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_dbus_en = 1'b1;
        st_addr    = a;
        st_data    = d;
        st_strb    = s;
        cyc();
        wr_dbus_en = 1'b0;
    endtask

    initial begin
        bit acc;
        bit done;
        int k;
        n_checks   = 0;
        n_errors   = 0;
        m_req      = 1'b0;
        m_err      = 1'b0;
        rst        = 1'b1;
        wr_dbus_en = 1'b0;
        st_addr    = '0;
        st_data    = '0;
        st_strb    = '0;
        dbus_ack   = 1'b0;
        dbus_err   = 1'b0;

        // Reset state
        repeat (3) cyc();
        check("rst_req",   dbus_req,   1'b0);
        check("rst_addr",  dbus_addr,  32'h0);
        check("rst_wdata", dbus_wdata, 32'h0);
        check("rst_wstrb", dbus_wstrb, 4'h0);
        check("rst_err",   st_err,     1'b0);
        check("rst_empty", sb_empty,   1'b1);
        check("rst_stall", st_stall,   1'b0);
        rst = 1'b0;
        cyc();

        // Single store with ack held high
        dbus_ack = 1'b1;
        push(32'h100, 32'hDEADBEEF, 4'hF);
        check("single_req_lat", dbus_req, 1'b0);
        cyc();
        check("single_req",   dbus_req,   1'b1);
        check("single_addr",  dbus_addr,  32'h100);
        check("single_wdata", dbus_wdata, 32'hDEADBEEF);
        check("single_wstrb", dbus_wstrb, 4'hF);
        cyc();
        check("single_done_req",   dbus_req, 1'b0);
        check("single_done_empty", sb_empty, 1'b1);

        // Fill to full with no acks; fifth store is refused
        dbus_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(32'(i * 4), $urandom, 4'hF);
            if (i == 3) check("fill_stall4", st_stall, 1'b1);
        end
        check("fill_stall5", st_stall, 1'b1);
        check("fill_cnt", mq.size(), DEPTH);
        repeat (3) begin
            cyc();
            check("fill_hold_addr", dbus_addr, 32'h0);
            check("fill_hold_req",  dbus_req,  1'b1);
        end

        // Back-to-back drain
        dbus_ack = 1'b1;
        for (int i = 1; i < 4; i++) begin
            cyc();
            check("b2b_addr", dbus_addr, 32'(i * 4));
            if (i == 1) check("b2b_stall", st_stall, 1'b0);
        end
        cyc();
        dbus_ack = 1'b0;
        check("b2b_req_drop", dbus_req, 1'b0);
        check("b2b_empty",    sb_empty, 1'b1);

        // Wrap-around: ten stores, random acks, then drain
        k    = 0;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            wr_dbus_en = (k < 10);
            st_addr    = 32'h1000 + 32'(k * 4);
            st_data    = $urandom;
            st_strb    = 4'($urandom_range(1, 15));
            dbus_ack   = (k >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
            acc        = wr_dbus_en && (mq.size() < DEPTH);
            cyc();
            if (acc) k++;
            done = (k == 10) && (mq.size() == 0) && !m_req;
        end
        wr_dbus_en = 1'b0;
        dbus_ack   = 1'b0;
        check("wrap_done",  done,     1'b1);
        check("wrap_empty", sb_empty, 1'b1);

        // Bus error on the second transaction
        push(32'h200, 32'h11111111, 4'h1);
        push(32'h204, 32'h22222222, 4'h3);
        push(32'h208, 32'h33333333, 4'hC);
        cyc();
        check("err_first_addr", dbus_addr, 32'h200);
        dbus_ack = 1'b1;
        cyc();
        check("err_second_addr", dbus_addr, 32'h204);
        check("err_no_pulse",    st_err,    1'b0);
        dbus_err = 1'b1;
        cyc();
        check("err_pulse",      st_err,    1'b1);
        check("err_third_addr", dbus_addr, 32'h208);
        check("err_third_req",  dbus_req,  1'b1);
        dbus_ack = 1'b0;
        dbus_err = 1'b0;
        cyc();
        check("err_pulse_end", st_err, 1'b0);
        dbus_ack = 1'b1;
        cyc();
        dbus_ack = 1'b0;
        cyc();
        check("err_empty", sb_empty, 1'b1);

        // Asynchronous reset while a request is outstanding
        push(32'h300, 32'hA, 4'hF);
        push(32'h304, 32'hB, 4'hF);
        push(32'h308, 32'hC, 4'hF);
        check("mid_req", dbus_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_req",   dbus_req, 1'b0);
        check("async_empty", sb_empty, 1'b1);
        check("async_stall", st_stall, 1'b0);
        mq.delete();
        m_req = 1'b0;
        m_err = 1'b0;
        cyc();
        cyc();
        rst      = 1'b0;
        dbus_ack = 1'b1;
        repeat (4) cyc();
        check("post_rst_req",   dbus_req, 1'b0);
        check("post_rst_empty", sb_empty, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_store_buf
`default_nettype wire

// File: doc/store_buf.md
Name: store_buf

Overview:
- Store buffer directly downstream of the writeback-enable stage.
- Captures each store qualified by wr_dbus_en (address, data, byte strobes) into a small FIFO.
- Drains the FIFO onto the data bus with a req/ack handshake, so bus latency is decoupled from the pipeline.
- Back-pressures upstream with st_stall when full; reports empty for fence/drain checks.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- AW, 32, address width.
- DW, 32, data width; strobe width is DW/8.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- wr_dbus_en  in  1  store commit strobe from writeback; one store per cycle when high.
- st_addr  in  AW  store byte address, valid with wr_dbus_en.
- st_data  in  DW  store data, lane-aligned.
- st_strb  in  DW/8  byte enables.
- st_stall  out  1  FIFO full; upstream must hold its store and re-present it.
- sb_empty  out  1  FIFO empty and no bus transaction outstanding.
- dbus_req  out  1  bus request.
- dbus_we  out  1  write qualifier; equals dbus_req.
- dbus_addr  out  AW  bus address.
- dbus_wdata  out  DW  bus write data.
- dbus_wstrb  out  DW/8  bus byte enables.
- dbus_ack  in  1  bus accept/complete; sampled only while dbus_req=1.
- dbus_err  in  1  bus error, valid with dbus_ack.
- st_err  out  1  one-cycle pulse; registered copy of (dbus_ack & dbus_err & dbus_req).

Behaviour:
- Reset (async, rst=1):
  - wr_ptr, rd_ptr, count = 0; state = IDLE.
  - dbus_req = dbus_we = 0; dbus_addr, dbus_wdata, dbus_wstrb = 0; st_err = 0.
  - sb_empty = 1; st_stall = 0.
  - Reset mid-transaction drops all entries and the in-flight request; no completion is reported.
- FIFO:
  - count is $clog2(DEPTH)+1 bits; pointers are $clog2(DEPTH) bits and wrap naturally.
  - st_stall = (count == DEPTH); combinational from registered count.
  - Push when wr_dbus_en & ~st_stall: write at wr_ptr, wr_ptr+1.
  - wr_dbus_en while full: not accepted, no state change.
  - A pop in the same cycle does not free the slot for that cycle's push.
  - Pop happens on handshake completion (dbus_req & dbus_ack): rd_ptr+1.
  - Push and pop in the same cycle leave count unchanged.
- Bus FSM, two states:
  - IDLE: if count != 0, register entry[rd_ptr] onto dbus_addr/wdata/wstrb, set dbus_req=1, go REQ.
  - IDLE: a store pushed in cycle N reaches dbus_req=1 at N+1 at the earliest.
  - IDLE: there is no combinational bypass from push to the bus.
  - REQ: dbus_addr, dbus_wdata, dbus_wstrb and dbus_req are held stable until dbus_ack.
  - REQ, on ack with (count - 1) != 0: load entry[rd_ptr+1] next cycle and stay REQ. This is back-to-back; one transaction per cycle is possible.
  - REQ, on ack with (count - 1) == 0: dbus_req = 0 next cycle, go IDLE.
  - A push coinciding with the last ack does not create a back-to-back transfer; it is issued from IDLE one cycle later.
- sb_empty = (count == 0) & (state == IDLE).
- Ordering: strictly FIFO. No merging, no reordering, no load forwarding.
- dbus_err: the entry is still popped, so there is no retry. st_err pulses in the following cycle.

Decomposition:
- Shared package core_pkg:
  - DBUS_AW, DBUS_DW constants.
  - sb_entry_t packed struct {addr, data, strb}.
  - sb_state_e enum {SB_IDLE, SB_REQ}.
- One sub-module, sync_fifo: a generic DEPTH x WIDTH register FIFO exposing push/pop/full/empty/count/head.
  - store_buf instantiates sync_fifo with WIDTH = $bits(sb_entry_t) and adds the bus FSM.

Test Plan:
- Single store, ack held high:
  - Stimulus: wr_dbus_en for 1 cycle with addr 0x100, data 0xDEADBEEF, strb 0xF.
  - Response: dbus_req=1 the next cycle with those values; ack the cycle after; dbus_req=0 after that; sb_empty returns to 1.
- Fill to full with dbus_ack=0:
  - Stimulus: 5 consecutive pushes with addr 0x0, 0x4, 0x8, 0xC, 0x10.
  - Response: st_stall=1 after the 4th push; the 5th is not accepted; bus holds addr 0x0 stably for the whole time.
- Back-to-back drain:
  - Stimulus: full FIFO, then dbus_ack tied to 1.
  - Response: addresses 0x0, 0x4, 0x8, 0xC appear on 4 consecutive cycles; dbus_req drops the next cycle; st_stall drops after the first ack.
- Wrap-around:
  - Stimulus: 10 stores with interleaved random acks.
  - Response: bus sequence equals push order exactly; count never exceeds 4; sb_empty=1 at the end.
- Error:
  - Stimulus: ack with dbus_err=1 on the 2nd transaction.
  - Response: st_err=1 for exactly one cycle, one cycle after that ack; the 3rd store still issues.
- Reset mid-REQ:
  - Stimulus: assert rst while dbus_req=1 with 3 entries queued.
  - Response: dbus_req=0, sb_empty=1, st_stall=0 immediately (async); no stale store issues after rst deasserts.
